vga_sprite_sched: RTL
=====================

Name: vga_sprite_sched

Overview:
- Per-pixel scheduler that shares one synchronous sprite ROM among NSPR on-screen sprites (paddles, ball, banners).
- Takes hc/vc/blank from the VGA controller and resolves which sprite covers the pixel by fixed priority.
- Issues one ROM read per pixel and applies colour-key transparency and blanking to produce registered RGB332.
- Sprite placement is written through a shadow-register port and committed atomically once per frame, so positions never tear mid-frame.

Parameters:
- NSPR, 4, number of sprite slots; slot 0 has highest priority.
- ROM_AW, 15, ROM address width.
- TRANS_KEY, 8'hE3, RGB332 value treated as transparent.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- hc  in  11  current horizontal pixel
- vc  in  11  current vertical pixel
- blank  in  1  1 = outside visible area
- frame_tick  in  1  one-cycle pulse at start of vertical blank
- cfg_we  in  1  shadow write strobe
- cfg_idx  in  $clog2(NSPR)  slot to write
- cfg_en  in  1  slot enable
- cfg_x0, cfg_y0  in  11 each  top-left position
- cfg_w, cfg_h  in  10 each  sprite width/height in pixels
- cfg_base  in  ROM_AW  ROM base address of the sprite image
- cfg_ready  out  1  1 = shadow writes accepted
- cfg_pending  out  1  1 = shadow differs from active (awaiting commit)
- rom_addr  out  ROM_AW  ROM address (registered)
- mem_value  in  8  ROM data, valid one clock after rom_addr
- bg_color  in  8  colour when no visible sprite covers the pixel
- R  out  3, G  out  3, B  out  2  registered pixel colour
- hit_id  out  $clog2(NSPR)+1  registered winning slot; NSPR = none

Behaviour:
- Reset (async, rst_n=0):
  - All active and shadow slots cleared, enables 0.
  - rom_addr=0, {R,G,B}=0, hit_id=NSPR.
  - Config FSM in IDLE, cfg_ready=1, cfg_pending=0.
- Pipeline, three clocks from hc/vc to RGB:
  - S1: slot i hits if en_i & hc>=x0_i & hc<x0_i+w_i & vc>=y0_i & vc<y0_i+h_i. Right/bottom bounds are computed in 12 bits, so there is no wrap at screen edge.
  - S1 winner is the lowest hit index. rom_addr <= base + dy*w + dx, with dx=hc-x0 and dy=vc-y0, truncated mod 2^ROM_AW. When there is no hit, rom_addr holds its previous value.
  - S2: hit and blank delayed one stage while the ROM returns mem_value.
  - S3 output: blank -> 0; no hit -> bg_color; mem_value==TRANS_KEY -> bg_color; else mem_value.
  - Transparent pixels never fall through to a lower-priority sprite (single ROM read per pixel).
- Config FSM:
  - IDLE: cfg_we writes the shadow slot -> PENDING.
  - PENDING: further writes accepted. frame_tick -> COMMIT.
  - COMMIT (exactly 1 clock): all shadow slots copied to active, cfg_ready=0, cfg_we ignored -> IDLE.
  - cfg_we in the same cycle as frame_tick is written to shadow and included in that commit.
  - frame_tick in IDLE: no effect.
  - cfg_pending=1 in PENDING, 0 otherwise.
  - Active registers change only in COMMIT. The pipeline keeps its state across commits.
- Reset mid-frame: outputs return to reset values immediately. The first valid RGB appears 3 clocks after rst_n rises.

Decomposition:
- Package vga_sprite_pkg: RGB332 field widths, TRANS_KEY default, sprite descriptor struct {en,x0,y0,w,h,base}.
- Sub-module sprite_hit (one per slot, generate loop): combinational hit flag plus dx/dy for a single descriptor.

Test Plan:
- Slot0 {x0=100,y0=50,w=16,h=16,base=0} committed; pixel (103,52) -> rom_addr=35 after 1 clk; RGB=mem_value 3 clks after the pixel.
- Slots 0 and 1 overlap at (120,60); mem_value=8'h1C for both -> hit_id=0, RGB from slot0's address.
- Slot0 returns TRANS_KEY at a covered pixel, slot1 also covers it, bg_color=8'h03 -> RGB=8'h03, hit_id=0.
- Write slot2 x0=200 mid-frame -> active unchanged and cfg_pending=1 until frame_tick. After frame_tick, COMMIT for 1 clk with cfg_ready=0, then new position in effect.
- cfg_we with frame_tick in the same cycle -> value committed in that COMMIT. cfg_we during COMMIT -> ignored, shadow unchanged.
- blank=1 over a sprite -> RGB=0. Assert rst_n=0 mid-line -> RGB=0, hit_id=NSPR, enables 0 immediately.

Source files
------------

// File: rtl/vga_sprite_pkg.sv
// Shared types for the sprite scheduler: RGB332 field widths, default colour key,
// per-slot sprite descriptor and config FSM state encoding.
// No logic, no latency, no backpressure.
package vga_sprite_pkg;

  localparam int R_W     = 3;
  localparam int G_W     = 3;
  localparam int B_W     = 2;
  localparam int PIX_W   = R_W + G_W + B_W;
  localparam int COORD_W = 11;
  localparam int SIZE_W  = 10;
  // Descriptors carry a base wide enough for any ROM up to 16M entries; the top
  // truncates the final address to its own ROM_AW.
  localparam int BASE_W  = 24;

  localparam logic [PIX_W-1:0] TRANS_KEY_DEF = 8'hE3;

  typedef struct packed {
    logic               en;
    logic [COORD_W-1:0] x0;
    logic [COORD_W-1:0] y0;
    logic [SIZE_W-1:0]  w;
    logic [SIZE_W-1:0]  h;
    logic [BASE_W-1:0]  base;
  } spr_desc_t;

  typedef enum logic [1:0] {
    CFG_IDLE    = 2'd0,
    CFG_PENDING = 2'd1,
    CFG_COMMIT  = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/sprite_hit.sv
// Coverage test for one sprite slot: hit flag plus pixel offset inside the sprite.
// Purely combinational, zero latency, no backpressure.
// Ports: en/x0/y0/w/h = slot descriptor fields, hc/vc = pixel, hit/dx/dy = result.
module sprite_hit
  import vga_sprite_pkg::*;
(
  input  logic               en,
  input  logic [COORD_W-1:0] x0,
  input  logic [COORD_W-1:0] y0,
  input  logic [SIZE_W-1:0]  w,
  input  logic [SIZE_W-1:0]  h,
  input  logic [COORD_W-1:0] hc,
  input  logic [COORD_W-1:0] vc,
  output logic               hit,
  output logic [COORD_W-1:0] dx,
  output logic [COORD_W-1:0] dy
);

  // One extra bit so a sprite hanging off the right/bottom edge does not wrap to 0.
  logic [COORD_W:0] x_end;
  logic [COORD_W:0] y_end;

  assign x_end = {1'b0, x0} + {2'b00, w};
  assign y_end = {1'b0, y0} + {2'b00, h};

  assign hit = en && (hc >= x0) && ({1'b0, hc} < x_end)
                  && (vc >= y0) && ({1'b0, vc} < y_end);
  assign dx  = hc - x0;
  assign dy  = vc - y0;

endmodule

// File: rtl/vga_sprite_sched.sv
// Per-pixel sprite scheduler: fixed-priority hit resolve, one shared ROM read, colour-key
// transparency and blanking to RGB332. Latency 3 clocks from hc/vc to R/G/B and hit_id.
// Backpressure: cfg_ready drops for the single commit clock; writes then are dropped.
// Ports: hc/vc/blank/frame_tick from the VGA timing; cfg_* shadow write port with
// cfg_ready/cfg_pending status; rom_addr/mem_value synchronous ROM; bg_color fill;
// R/G/B registered colour; hit_id winning slot (NSPR = none).
module vga_sprite_sched
  import vga_sprite_pkg::*;
#(
  parameter int               NSPR      = 4,
  parameter int               ROM_AW    = 15,
  parameter logic [PIX_W-1:0] TRANS_KEY = TRANS_KEY_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [COORD_W-1:0]      hc,
  input  logic [COORD_W-1:0]      vc,
  input  logic                    blank,
  input  logic                    frame_tick,
  input  logic                    cfg_we,
  input  logic [$clog2(NSPR)-1:0] cfg_idx,
  input  logic                    cfg_en,
  input  logic [COORD_W-1:0]      cfg_x0,
  input  logic [COORD_W-1:0]      cfg_y0,
  input  logic [SIZE_W-1:0]       cfg_w,
  input  logic [SIZE_W-1:0]       cfg_h,
  input  logic [ROM_AW-1:0]       cfg_base,
  output logic                    cfg_ready,
  output logic                    cfg_pending,
  output logic [ROM_AW-1:0]       rom_addr,
  input  logic [PIX_W-1:0]        mem_value,
  input  logic [PIX_W-1:0]        bg_color,
  output logic [R_W-1:0]          R,
  output logic [G_W-1:0]          G,
  output logic [B_W-1:0]          B,
  output logic [$clog2(NSPR):0]   hit_id
);

  localparam int             IW     = $clog2(NSPR);
  localparam int             IDW    = IW + 1;
  localparam logic [IW:0]    NO_HIT = IDW'(NSPR);

  // ---------------- configuration: shadow slots, atomic per-frame commit ----------------
  cfg_state_t state;
  spr_desc_t  shadow [NSPR];
  spr_desc_t  active [NSPR];
  spr_desc_t  cfg_desc;

  assign cfg_desc = '{en: cfg_en, x0: cfg_x0, y0: cfg_y0, w: cfg_w, h: cfg_h,
                      base: BASE_W'(cfg_base)};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= CFG_IDLE;
      cfg_ready   <= 1'b1;
      cfg_pending <= 1'b0;
      for (int i = 0; i < NSPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      case (state)
        CFG_IDLE: begin
          if (cfg_we) begin
            shadow[cfg_idx] <= cfg_desc;
            state           <= CFG_PENDING;
            cfg_pending     <= 1'b1;
          end
        end
        CFG_PENDING: begin
          // A write landing with frame_tick is already in shadow when COMMIT copies it.
          if (cfg_we) shadow[cfg_idx] <= cfg_desc;
          if (frame_tick) begin
            state       <= CFG_COMMIT;
            cfg_ready   <= 1'b0;
            cfg_pending <= 1'b0;
          end
        end
        CFG_COMMIT: begin
          for (int i = 0; i < NSPR; i++) active[i] <= shadow[i];
          state     <= CFG_IDLE;
          cfg_ready <= 1'b1;
        end
        default: begin
          state       <= CFG_IDLE;
          cfg_ready   <= 1'b1;
          cfg_pending <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- S1: per-slot hit test and priority resolve ----------------
  logic [NSPR-1:0]    hit_v;
  logic [COORD_W-1:0] dx_v [NSPR];
  logic [COORD_W-1:0] dy_v [NSPR];

  for (genvar g = 0; g < NSPR; g++) begin : g_hit
    sprite_hit u_hit (
      .en  (active[g].en),
      .x0  (active[g].x0),
      .y0  (active[g].y0),
      .w   (active[g].w),
      .h   (active[g].h),
      .hc  (hc),
      .vc  (vc),
      .hit (hit_v[g]),
      .dx  (dx_v[g]),
      .dy  (dy_v[g])
    );
  end

  logic [IW:0]       win_id;
  logic [ROM_AW-1:0] win_addr;

  // Scan from lowest priority upward so the lowest hit index wins last.
  always_comb begin
    win_id   = NO_HIT;
    win_addr = rom_addr;
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (hit_v[i]) begin
        win_id   = IDW'(i);
        win_addr = ROM_AW'(32'(active[i].base) + 32'(dy_v[i]) * 32'(active[i].w)
                           + 32'(dx_v[i]));
      end
    end
  end

  // ---------------- S1/S2/S3 pipeline registers ----------------
  logic [IW:0]      id1, id2;
  logic             blank1, blank2;
  logic [PIX_W-1:0] pix_next;

  // Transparent pixels show background; a lower-priority sprite is never re-read.
  always_comb begin
    pix_next = '0;
    if (!blank2) begin
      if (id2 == NO_HIT || mem_value == TRANS_KEY) pix_next = bg_color;
      else                                         pix_next = mem_value;
    end
  end

  // Stage blanks reset to 1 so nothing but 0 reaches RGB until a real pixel arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_addr  <= '0;
      id1       <= NO_HIT;
      id2       <= NO_HIT;
      blank1    <= 1'b1;
      blank2    <= 1'b1;
      {R, G, B} <= '0;
      hit_id    <= NO_HIT;
    end else begin
      rom_addr  <= win_addr;
      id1       <= win_id;
      blank1    <= blank;
      id2       <= id1;
      blank2    <= blank1;
      {R, G, B} <= pix_next;
      hit_id    <= id2;
    end
  end

endmodule
